// File: rtl/uart_boot_loader_if.sv
// Memory write port driven by the UART boot loader: byte address, little-endian
// data word and a one-cycle write strobe.
`timescale 1ns/1ps

interface uart_boot_loader_if;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_write_enable;

    modport master (output mem_address, output mem_data, output mem_write_enable);
    modport slave  (input  mem_address, input  mem_data, input  mem_write_enable);
endinterface

// File: rtl/uart_boot_loader.sv
// UART (8N1, 16x oversampled) boot loader: SYNC, 16-bit word count, little-endian words -> memory writes.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CSUM_EN.
`timescale 1ns/1ps

module uart_boot_loader #(
    parameter int          DVSR      = 326,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx,
    uart_boot_loader_if.master         mem,
    output logic                       cpu_stall,
    output logic                       done,
    output logic                       error
);

    localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_WAIT_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } sess_t;

`ifdef LOADER_CSUM_EN
    localparam sess_t S_FINAL = S_CSUM;
`else
    localparam sess_t S_FINAL = S_DONE;
`endif

    logic          rx_meta, rx_sync;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    rx_state_t     rx_state, rx_next;
    logic [3:0]    tick_num;
    logic [2:0]    bit_num;
    logic [7:0]    rx_byte;
    logic          byte_valid, frame_err;
    sess_t         s_state, s_next;
    logic [7:0]    len_lo;
    logic [15:0]   word_total, word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic          write_fire;

    // NOTE: sequential state uses <= only so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign tick = (tick_cnt == TW'(DVSR - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (tick && tick_num == 4'd7) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && tick_num == 4'd15 && bit_num == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (tick && tick_num == 4'd15) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (rx_state == RX_STOP && tick && tick_num == 4'd15) begin
            byte_valid = rx_sync;
            frame_err  = !rx_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_num <= '0;
            bit_num  <= '0;
            rx_byte  <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    tick_num <= '0;
                    bit_num  <= '0;
                end
                RX_START: if (tick) tick_num <= (tick_num == 4'd7) ? 4'd0 : tick_num + 4'd1;
                RX_DATA: if (tick) begin
                    tick_num <= tick_num + 4'd1;
                    if (tick_num == 4'd15) begin
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        bit_num <= bit_num + 3'd1;
                    end
                end
                RX_STOP: if (tick) tick_num <= tick_num + 4'd1;
                default: ;
            endcase
        end
    end

`ifdef LOADER_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (byte_valid) begin
            if (s_state == S_WAIT_SYNC || s_state == S_DONE || s_state == S_ERR)
                csum <= '0;
            else if (s_state == S_LEN_LO || s_state == S_LEN_HI || s_state == S_DATA)
                csum <= csum ^ rx_byte;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) s_state <= S_WAIT_SYNC;
        else       s_state <= s_next;
    end

    // A framing fault aborts any running or finished session; idle line noise is ignored.
    always_comb begin
        s_next = s_state;
        if (frame_err && s_state != S_WAIT_SYNC) begin
            s_next = S_ERR;
        end else if (byte_valid) begin
            case (s_state)
                S_WAIT_SYNC, S_DONE, S_ERR: if (rx_byte == SYNC_BYTE) s_next = S_LEN_LO;
                S_LEN_LO: s_next = S_LEN_HI;
                S_LEN_HI: s_next = ({rx_byte, len_lo} == 16'd0) ? S_FINAL : S_DATA;
                S_DATA:   if (byte_idx == 2'd3 && word_idx == word_total - 16'd1) s_next = S_FINAL;
`ifdef LOADER_CSUM_EN
                S_CSUM:   s_next = (rx_byte == csum) ? S_DONE : S_ERR;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_stall  = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        write_fire = 1'b0;
        case (s_state)
            S_LEN_LO, S_LEN_HI, S_CSUM: cpu_stall = 1'b1;
            S_DATA: begin
                cpu_stall  = 1'b1;
                write_fire = byte_valid && byte_idx == 2'd3;
            end
            S_DONE: done  = 1'b1;
            S_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo               <= '0;
            word_total           <= '0;
            word_idx             <= '0;
            byte_idx             <= '0;
            word_buf             <= '0;
            mem.mem_address      <= '0;
            mem.mem_data         <= '0;
            mem.mem_write_enable <= 1'b0;
        end else begin
            mem.mem_write_enable <= write_fire;
            if (byte_valid) begin
                case (s_state)
                    S_WAIT_SYNC, S_DONE, S_ERR: if (rx_byte == SYNC_BYTE) begin
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                    S_LEN_LO: len_lo     <= rx_byte;
                    S_LEN_HI: word_total <= {rx_byte, len_lo};
                    S_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_byte;
                            2'd1: word_buf[15:8]  <= rx_byte;
                            2'd2: word_buf[23:16] <= rx_byte;
                            default: begin
                                mem.mem_address <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                                mem.mem_data    <= {rx_byte, word_buf};
                                word_idx        <= word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: serial host driver, queue-based write model,
// per-cycle write/hold compare, session status checks. Honours LOADER_CSUM_EN.
`timescale 1ns/1ps

module tb_uart_boot_loader;

    localparam int          DVSR = 4;
    localparam int          BIT  = 16 * DVSR;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic cpu_stall, done, error;

    uart_boot_loader_if bus();

    uart_boot_loader #(.DVSR(DVSR), .BASE_ADDR(BASE), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx(rx), .mem(bus),
        .cpu_stall(cpu_stall), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] wbuf[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic status(input string tag, input logic s, input logic d, input logic e);
        check({tag, "_stall"}, 32'(cpu_stall), 32'(s));
        check({tag, "_done"},  32'(done),      32'(d));
        check({tag, "_error"}, 32'(error),     32'(e));
    endtask

    // Every strobe must match the next expected write; between strobes the bus holds.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_write_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got addr %h data %h, expected no write at %0t",
                             bus.mem_address, bus.mem_data, $time);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", bus.mem_address, e[63:32]);
                    check("wr_data", bus.mem_data, e[31:0]);
                    last_addr = e[63:32];
                    last_data = e[31:0];
                end
            end else begin
                check("hold_addr", bus.mem_address, last_addr);
                check("hold_data", bus.mem_data, last_data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
        @(negedge clk) rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        if (bad_stop) begin
            rx = 1'b0;
            repeat (48) @(negedge clk);
            rx = 1'b1;
            repeat (2 * BIT) @(negedge clk);
        end else begin
            rx = 1'b1;
            repeat (BIT + $urandom_range(0, 15)) @(negedge clk);
        end
    endtask

    task automatic session(input int n, input int junk, input bit bad_csum, input bit model_push);
        logic [7:0] b;
        logic [7:0] cs;
        bit         bad;
        for (int j = 0; j < junk; j++) begin
            do b = 8'($urandom); while (b == 8'hA5);
            send_byte(b);
        end
        send_byte(8'hA5);
        status("sync", 1'b1, 1'b0, 1'b0);
        cs = 8'(n) ^ 8'(n >> 8);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b  = 8'(wbuf[i] >> (8 * k));
                cs = cs ^ b;
                if (k == 3 && model_push) exp_q.push_back({BASE + 32'(4 * i), wbuf[i]});
                send_byte(b);
            end
        end
`ifdef LOADER_CSUM_EN
        send_byte(bad_csum ? (cs ^ 8'h01) : cs);
        bad = bad_csum;
`else
        bad = 1'b0;
`endif
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        status("end", 1'b0, !bad, bad);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        status("reset", 1'b0, 1'b0, 1'b0);
        check("reset_we", 32'(bus.mem_write_enable), 32'd0);

        // framing error with no session running is ignored
        send_byte(8'h5A, 1'b1);
        status("idle_ferr", 1'b0, 1'b0, 1'b0);

        // 3-clk glitch while idle
        @(negedge clk) rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        status("glitch", 1'b0, 1'b0, 1'b0);

        // two-word session, literal expectations
        wbuf[0] = 32'h1234_5678;
        wbuf[1] = 32'hDEAD_BEEF;
        exp_q.push_back({32'hFFFF_FFF8, 32'h1234_5678});
        exp_q.push_back({32'hFFFF_FFFC, 32'hDEAD_BEEF});
        session(2, 0, 1'b0, 1'b0);

        @(negedge clk) rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        status("glitch_done", 1'b0, 1'b1, 1'b0);

        // leading junk ignored
        send_byte(8'h3C);
        send_byte(8'h00);
        wbuf[0] = 32'h4433_2211;
        exp_q.push_back({32'hFFFF_FFF8, 32'h4433_2211});
        session(1, 0, 1'b0, 1'b0);

        // framing error mid-word: no strobe, error set
        send_byte(8'hA5);
        status("ferr_sync", 1'b1, 1'b0, 1'b0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33, 1'b1);
        status("ferr", 1'b0, 1'b0, 1'b1);
        wbuf[0] = $urandom;
        session(1, 0, 1'b0, 1'b1);

        // zero-length session
        session(0, 0, 1'b0, 1'b1);

        // randomized sessions; the first wraps past 2^32
        for (int s = 0; s < 2; s++) begin
            int n;
            n = (s == 0) ? 3 : $urandom_range(1, 3);
            for (int i = 0; i < n; i++) wbuf[i] = $urandom;
            session(n, $urandom_range(0, 1), 1'b0, 1'b1);
        end

`ifdef LOADER_CSUM_EN
        wbuf[0] = 32'h0403_0201;
        exp_q.push_back({32'hFFFF_FFF8, 32'h0403_0201});
        session(1, 0, 1'b0, 1'b0);
        exp_q.push_back({32'hFFFF_FFF8, 32'h0403_0201});
        session(1, 0, 1'b1, 1'b0);
`endif

        // reset mid-word of a 3-word session
        wbuf[0] = $urandom;
        wbuf[1] = $urandom;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back({BASE, wbuf[0]});
            send_byte(8'(wbuf[0] >> (8 * k)));
        end
        send_byte(8'(wbuf[1]));
        send_byte(8'(wbuf[1] >> 8));
        check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk) rx = 1'b0;
        repeat (BIT + 20) @(negedge clk);
        #2 reset = 1'b1;
        last_addr = '0;
        last_data = '0;
        #1;
        status("async_reset", 1'b0, 1'b0, 1'b0);
        check("async_reset_addr", bus.mem_address, 32'd0);
        check("async_reset_data", bus.mem_data, 32'd0);
        check("async_reset_we", 32'(bus.mem_write_enable), 32'd0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        status("post_reset", 1'b0, 1'b0, 1'b0);
        wbuf[0] = $urandom;
        wbuf[1] = $urandom;
        session(2, 0, 1'b0, 1'b1);

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
